// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory read port plus the slot/control signals
// shared with decode and the later redirecting stages.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;

    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic [15:0] instruction;
    logic [15:0] pc_plus2;
    logic        inst_valid;
    logic        halted;
    logic        err;

    modport master (
        output imem_req, imem_addr, instruction, pc_plus2, inst_valid, halted, err,
        input  imem_rdy, imem_data, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instruction, pc_plus2, inst_valid, halted, err,
        output imem_rdy, imem_data, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and holds one
// fetched word (with its PC+2) in a slot for decode; handles stall, redirect, HALT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000,
    parameter logic [15:0] NOP_INSTR   = 16'h0800
) (
    input logic            clk,
    input logic            rst,
    fetch_stage_if.master  bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } stateType;

    stateType    state;
    logic [15:0] pc;
    logic [15:0] instrReg;
    logic [15:0] pcPlus2Reg;
    logic        instValidReg;
    logic        haltedReg;
    logic        errReg;

    logic        slotFree;
    logic        imemReq;
    logic        transfer;
    logic        consume;
    logic        redirectTaken;
    logic        spuriousRdy;
    logic        misaligned;
    logic        isHalt;
    logic [15:0] pcNext;

    // The request must drop in the same cycle as a redirect, so it is combinational.
    assign slotFree      = !instValidReg || !bus.stall;
    assign imemReq       = (state == FETCH) && slotFree && !bus.redirect;
    assign transfer      = imemReq && bus.imem_rdy;
    assign consume       = instValidReg && !bus.stall;
    assign redirectTaken = bus.redirect && (state != BOOT);
    assign spuriousRdy   = bus.imem_rdy && !imemReq && (state != BOOT);
    assign misaligned    = redirectTaken && bus.redirect_pc[0];
    assign isHalt        = (bus.imem_data[15:11] == HALT_OPCODE);
    assign pcNext        = pc + 16'd2;

    // NOTE: every register below uses <= so all decisions see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            instrReg     <= NOP_INSTR;
            pcPlus2Reg   <= 16'h0000;
            instValidReg <= 1'b0;
            haltedReg    <= 1'b0;
            errReg       <= 1'b0;
        end else begin
            if (misaligned || spuriousRdy) begin
                errReg <= 1'b1;
            end

            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                default: begin
                    if (redirectTaken) begin
                        // Flush wins over stall, transfer and a HALT in flight.
                        pc           <= bus.redirect_pc;
                        instValidReg <= 1'b0;
                        instrReg     <= NOP_INSTR;
                        haltedReg    <= 1'b0;
                        state        <= FETCH;
                    end else if (transfer) begin
                        instrReg     <= bus.imem_data;
                        pcPlus2Reg   <= pcNext;
                        pc           <= pcNext;
                        instValidReg <= 1'b1;
                        if (isHalt) begin
                            state     <= HALTED;
                            haltedReg <= 1'b1;
                        end
                    end else if (consume) begin
                        instValidReg <= 1'b0;
                        instrReg     <= NOP_INSTR;
                    end
                end
            endcase
        end
    end

    assign bus.imem_req    = imemReq;
    assign bus.imem_addr   = pc;
    assign bus.instruction = instrReg;
    assign bus.pc_plus2    = pcPlus2Reg;
    assign bus.inst_valid  = instValidReg;
    assign bus.halted      = haltedReg;
    assign bus.err         = errReg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected slot contents into a
// scoreboard queue and a negedge monitor pops them whenever decode consumes.
module tb_fetch_stage;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pcp2;
    } expType;

    logic clk;
    logic rst;
    logic rdyEn;
    logic spurRdy;
    int   errCount;
    int   checkCount;
    expType sbQueue[$];

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: HALT at 0x0010, elsewhere opcode 01000 with a per-address tag.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        logic [10:0] tag;
        tag = a[11:1] + 11'd1;
        if (a == 16'h0010) return 16'h0000;
        return {5'b01000, tag};
    endfunction

    assign bus.imem_data = memWord(bus.imem_addr);
    assign bus.imem_rdy  = (bus.imem_req & rdyEn) | spurRdy;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] pcp2);
        expType e;
        e.instr = instr;
        e.pcp2  = pcp2;
        sbQueue.push_back(e);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_instr"},  bus.instruction, 16'h0800);
        check({tag, "_pcp2"},   bus.pc_plus2,    16'h0000);
        check({tag, "_valid"},  16'(bus.inst_valid), 16'h0000);
        check({tag, "_halted"}, 16'(bus.halted),     16'h0000);
        check({tag, "_err"},    16'(bus.err),        16'h0000);
        check({tag, "_req"},    16'(bus.imem_req),   16'h0000);
        check({tag, "_addr"},   bus.imem_addr,   16'h0000);
    endtask

    // Monitor: a slot is consumed at the coming edge when valid, not stalled, not flushed.
    always @(negedge clk) begin
        if (rst && bus.inst_valid && !bus.stall && !bus.redirect) begin
            if (sbQueue.size() == 0) begin
                checkCount++;
                errCount++;
                $display("FAIL sb_unexpected: got %h/%h expected no word at %0t",
                         bus.instruction, bus.pc_plus2, $time);
            end else begin
                expType e;
                e = sbQueue.pop_front();
                check("sb_instr", bus.instruction, e.instr);
                check("sb_pcp2",  bus.pc_plus2,    e.pcp2);
            end
        end
    end

    initial begin
        errCount        = 0;
        checkCount      = 0;
        rst             = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        rdyEn           = 1'b1;
        spurRdy         = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("rst");

        // Release into BOOT with a stray ready that must not raise err.
        spurRdy = 1'b1;
        rst     = 1'b1;
        tick();
        spurRdy = 1'b0;
        #1;
        check("boot_err",    16'(bus.err),        16'h0000);
        check("boot_valid",  16'(bus.inst_valid), 16'h0000);
        check("fetch_req",   16'(bus.imem_req),   16'h0001);
        check("fetch_addr0", bus.imem_addr,       16'h0000);
        push(16'h4001, 16'h0002);
        push(16'h4002, 16'h0004);
        push(16'h4003, 16'h0006);
        tick();
        check("first_valid", 16'(bus.inst_valid), 16'h0001);
        check("fetch_addr2", bus.imem_addr,       16'h0002);
        tick();
        check("fetch_addr4", bus.imem_addr,       16'h0004);

        // Stall with a valid slot: no request, PC and slot frozen.
        bus.stall = 1'b1;
        #1;
        check("stall_req", 16'(bus.imem_req), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr",  bus.imem_addr,     16'h0004);
            check("stall_instr", bus.instruction,   16'h4002);
            check("stall_pcp2",  bus.pc_plus2,      16'h0004);
            check("stall_req",   16'(bus.imem_req), 16'h0000);
        end
        bus.stall = 1'b0;
        tick();
        check("resume_addr", bus.imem_addr, 16'h0006);

        // Memory waits: request holds at the same address.
        rdyEn = 1'b0;
        tick();
        check("wait_valid", 16'(bus.inst_valid), 16'h0000);
        check("wait_addr",  bus.imem_addr,       16'h0006);
        check("wait_req",   16'(bus.imem_req),   16'h0001);

        // Redirect to 0x0040 during the wait.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        #1;
        check("redir_noreq", 16'(bus.imem_req), 16'h0000);
        tick();
        bus.redirect = 1'b0;
        check("redir_addr",  bus.imem_addr,       16'h0040);
        check("redir_valid", 16'(bus.inst_valid), 16'h0000);
        check("redir_err",   16'(bus.err),        16'h0000);
        push(16'h4021, 16'h0042);
        rdyEn = 1'b1;
        tick();
        check("redir_fetch_valid", 16'(bus.inst_valid), 16'h0001);
        rdyEn = 1'b0;
        tick();

        // Run into the HALT word at 0x0010.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h000C;
        tick();
        bus.redirect = 1'b0;
        rdyEn        = 1'b1;
        check("halt_start_addr", bus.imem_addr, 16'h000C);
        push(16'h4007, 16'h000E);
        push(16'h4008, 16'h0010);
        push(16'h0000, 16'h0012);
        repeat (3) tick();
        check("halt_halted", 16'(bus.halted),     16'h0001);
        check("halt_req",    16'(bus.imem_req),   16'h0000);
        check("halt_instr",  bus.instruction,     16'h0000);
        check("halt_pcp2",   bus.pc_plus2,        16'h0012);
        check("halt_valid",  16'(bus.inst_valid), 16'h0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halted_req",   16'(bus.imem_req),   16'h0000);
            check("halted_flag",  16'(bus.halted),     16'h0001);
            check("halted_valid", 16'(bus.inst_valid), 16'h0000);
        end

        // Redirect out of HALTED.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0020;
        tick();
        bus.redirect = 1'b0;
        check("unhalt_flag", 16'(bus.halted), 16'h0000);
        check("unhalt_addr", bus.imem_addr,   16'h0020);
        push(16'h4011, 16'h0022);
        tick();
        rdyEn = 1'b0;
        tick();

        // Misaligned redirect: err sets and sticks while fetch continues.
        rdyEn           = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0033;
        tick();
        bus.redirect = 1'b0;
        check("mis_err",  16'(bus.err), 16'h0001);
        check("mis_addr", bus.imem_addr, 16'h0033);
        push(16'h401A, 16'h0035);
        push(16'h401B, 16'h0037);
        tick();
        check("mis_err_hold1", 16'(bus.err), 16'h0001);
        tick();
        check("mis_err_hold2", 16'(bus.err), 16'h0001);

        // Asynchronous reset mid-fetch drops the slot immediately.
        #2;
        rst = 1'b0;
        #1;
        checkResetOutputs("midrst");
        sbQueue.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Wrap from 0xFFFE to 0x0000.
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        tick();
        bus.redirect = 1'b0;
        check("wrap_start", bus.imem_addr, 16'hFFFE);
        push(16'h4000, 16'h0000);
        tick();
        check("wrap_addr",  bus.imem_addr,       16'h0000);
        check("wrap_pcp2",  bus.pc_plus2,        16'h0000);
        check("wrap_err",   16'(bus.err),        16'h0000);
        check("wrap_valid", 16'(bus.inst_valid), 16'h0001);
        rdyEn = 1'b0;
        tick();

        // Ready without a request in FETCH raises err.
        rdyEn = 1'b1;
        push(16'h4001, 16'h0002);
        tick();
        bus.stall = 1'b1;
        rdyEn     = 1'b0;
        spurRdy   = 1'b1;
        #1;
        check("spur_req",     16'(bus.imem_req), 16'h0000);
        check("spur_err_pre", 16'(bus.err),      16'h0000);
        tick();
        check("spur_err", 16'(bus.err), 16'h0001);
        spurRdy   = 1'b0;
        bus.stall = 1'b0;
        tick();
        tick();

        check("sb_empty", 16'(sbQueue.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
